// File: rtl/round_sequencer.sv
// round_sequencer: per-round game controller (idle, ready countdown, timed play, result hold); STREAK_BONUS_EN adds the win-streak bonus
module round_sequencer #(
    parameter int READY_SECS  = 5,
    parameter int SLICES      = 10,
    parameter int MAX_DIFF    = 9,
    parameter int RESULT_SECS = 3,
    parameter int SCORE_W     = 8
) (
    input  logic               secclk,
    input  logic               resetn,
    input  logic               start,
    input  logic [3:0]         difficulty,
    input  logic               guess_valid,
    input  logic               guess_correct,
    output logic [1:0]         phase,
    output logic [2:0]         countdown,
    output logic [4:0]         progress,
    output logic [SCORE_W-1:0] score,
    output logic               win,
    output logic               timeout,
    output logic [2:0]         streak
);
    localparam int SW1 = SCORE_W + 1;
    typedef enum logic [1:0] {IDLE, READY, PLAY, RESULT} state_t;
    state_t st;
    logic [7:0] timer, tnew, dq, pen, hold;
    logic [3:0] diff_q, dsel;
    logic [4:0] pnew;
    logic [SW1-1:0] sum;
    assign phase = st;
    // next-timer, progress slice, clamped difficulty and saturating score candidates
    always_comb begin
        dsel = (difficulty == 4'd0) ? 4'd1 : (difficulty > 4'(MAX_DIFF)) ? 4'(MAX_DIFF) : difficulty;
        dq   = {4'd0, diff_q};
        pen  = dq + 8'd1;
        tnew = guess_valid ? ((timer > pen) ? timer - pen : 8'd0) : timer - 8'd1;
        pnew = 5'((tnew + dq - 8'd1) / dq);
        sum  = {1'b0, score} + SW1'(progress) + SW1'(streak);
    end
    // round phase state machine with registered outputs
    always_ff @(posedge secclk or negedge resetn) begin
        if (!resetn) begin
            st        <= IDLE;
            countdown <= 3'(READY_SECS);
            progress  <= 5'(SLICES);
            score     <= '0;
            win       <= 1'b0;
            timeout   <= 1'b0;
            timer     <= 8'd0;
            diff_q    <= 4'd1;
            hold      <= 8'd0;
        end else begin
            case (st)
                IDLE: if (start) begin
                    diff_q    <= dsel;
                    countdown <= 3'(READY_SECS);
                    win       <= 1'b0;
                    timeout   <= 1'b0;
                    st        <= READY;
                end
                READY: begin
                    countdown <= countdown - 3'd1;
                    if (countdown == 3'd1) begin
                        timer    <= 8'(SLICES) * dq;
                        progress <= 5'(SLICES);
                        st       <= PLAY;
                    end
                end
                PLAY: if (guess_valid && guess_correct) begin
                    win   <= 1'b1;
                    score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                    st    <= RESULT;
                end else begin
                    timer    <= tnew;
                    progress <= pnew;
                    if (tnew == 8'd0) begin
                        timeout <= 1'b1;
                        st      <= RESULT;
                    end
                end
                RESULT: if (hold == 8'(RESULT_SECS - 1)) begin
                    hold      <= 8'd0;
                    countdown <= 3'(READY_SECS);
                    st        <= IDLE;
                end else begin
                    hold <= hold + 8'd1;
                end
            endcase
        end
    end
`ifdef STREAK_BONUS_EN
    // consecutive-win counter: saturating increment on a win, cleared by a timeout
    always_ff @(posedge secclk or negedge resetn) begin
        if (!resetn)
            streak <= 3'd0;
        else if (st == PLAY && guess_valid && guess_correct)
            streak <= (streak == 3'd7) ? streak : streak + 3'd1;
        else if (st == PLAY && tnew == 8'd0)
            streak <= 3'd0;
    end
`else
    assign streak = 3'd0;
`endif
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed vector table plus hand-built round sequences for round_sequencer
module tb_round_sequencer;
    logic       secclk = 1'b0, resetn = 1'b0, start = 1'b0, guess_valid = 1'b0, guess_correct = 1'b0;
    logic [3:0] difficulty = 4'd0;
    logic [1:0] phase;
    logic [2:0] countdown, streak;
    logic [4:0] progress;
    logic [7:0] score;
    logic       win, timeout;
    int nvec = 0, nerr = 0, exp_score = 0, exp_streak = 0;
`ifdef STREAK_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif
    typedef struct packed {
        logic       st;
        logic [3:0] d;
        logic       gv, gc;
        logic [1:0] ph;
        logic [2:0] cd;
        logic [4:0] pr;
        logic       w, to;
        logic [7:0] sc;
        logic [2:0] sk;
    } vec_t;
    vec_t tbl [20];

    always #5 secclk = ~secclk;

    round_sequencer dut (
        .secclk(secclk), .resetn(resetn), .start(start), .difficulty(difficulty),
        .guess_valid(guess_valid), .guess_correct(guess_correct), .phase(phase),
        .countdown(countdown), .progress(progress), .score(score), .win(win),
        .timeout(timeout), .streak(streak)
    );

    task automatic tick();
        @(posedge secclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic win_m(input int p);
        exp_score += p + (BONUS ? exp_streak : 0);
        if (exp_score > 255) exp_score = 255;
        if (BONUS && exp_streak < 7) exp_streak++;
    endtask

    task automatic chk_model(input string name);
        chk({name, "_score"}, score, exp_score);
        chk({name, "_streak"}, streak, exp_streak);
    endtask

    task automatic begin_round(input logic [3:0] d);
        start = 1'b1;
        difficulty = d;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("enter_play", phase, 2);
        chk("enter_progress", progress, 10);
    endtask

    task automatic finish_result();
        guess_valid = 1'b0;
        guess_correct = 1'b0;
        tick();
        chk("hold1", phase, 3);
        tick();
        chk("hold2", phase, 3);
        tick();
        chk("back_idle", phase, 0);
        chk("idle_countdown", countdown, 5);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_phase"}, phase, 0);
        chk({name, "_cd"}, countdown, 5);
        chk({name, "_prog"}, progress, 10);
        chk({name, "_score"}, score, 0);
        chk({name, "_win"}, win, 0);
        chk({name, "_to"}, timeout, 0);
        chk({name, "_streak"}, streak, 0);
    endtask

    initial begin
        //          st  d    gv gc  ph cd pr  w  to sc sk
        tbl[0]  = {1'b1, 4'd3, 2'b00, 2'd1, 3'd5, 5'd10, 2'b00, 8'd0, 3'd0};
        tbl[1]  = {1'b0, 4'd3, 2'b00, 2'd1, 3'd4, 5'd10, 2'b00, 8'd0, 3'd0};
        tbl[2]  = {1'b0, 4'd3, 2'b00, 2'd1, 3'd3, 5'd10, 2'b00, 8'd0, 3'd0};
        tbl[3]  = {1'b0, 4'd3, 2'b11, 2'd1, 3'd2, 5'd10, 2'b00, 8'd0, 3'd0};
        tbl[4]  = {1'b0, 4'd3, 2'b00, 2'd1, 3'd1, 5'd10, 2'b00, 8'd0, 3'd0};
        tbl[5]  = {1'b0, 4'd3, 2'b00, 2'd2, 3'd0, 5'd10, 2'b00, 8'd0, 3'd0};
        tbl[6]  = {1'b0, 4'd3, 2'b00, 2'd2, 3'd0, 5'd10, 2'b00, 8'd0, 3'd0};
        tbl[7]  = {1'b0, 4'd3, 2'b00, 2'd2, 3'd0, 5'd10, 2'b00, 8'd0, 3'd0};
        tbl[8]  = {1'b0, 4'd3, 2'b00, 2'd2, 3'd0, 5'd9,  2'b00, 8'd0, 3'd0};
        tbl[9]  = {1'b0, 4'd3, 2'b11, 2'd3, 3'd0, 5'd9,  2'b10, 8'd9, 3'd1};
        tbl[10] = {1'b1, 4'd3, 2'b00, 2'd3, 3'd0, 5'd9,  2'b10, 8'd9, 3'd1};
        tbl[11] = {1'b1, 4'd3, 2'b00, 2'd3, 3'd0, 5'd9,  2'b10, 8'd9, 3'd1};
        tbl[12] = {1'b1, 4'd3, 2'b00, 2'd0, 3'd5, 5'd9,  2'b10, 8'd9, 3'd1};
        tbl[13] = {1'b1, 4'd2, 2'b00, 2'd1, 3'd5, 5'd9,  2'b00, 8'd9, 3'd1};
        tbl[14] = {1'b0, 4'd2, 2'b00, 2'd1, 3'd4, 5'd9,  2'b00, 8'd9, 3'd1};
        tbl[15] = {1'b0, 4'd2, 2'b00, 2'd1, 3'd3, 5'd9,  2'b00, 8'd9, 3'd1};
        tbl[16] = {1'b0, 4'd2, 2'b00, 2'd1, 3'd2, 5'd9,  2'b00, 8'd9, 3'd1};
        tbl[17] = {1'b0, 4'd2, 2'b00, 2'd1, 3'd1, 5'd9,  2'b00, 8'd9, 3'd1};
        tbl[18] = {1'b0, 4'd2, 2'b00, 2'd2, 3'd0, 5'd10, 2'b00, 8'd9, 3'd1};
        tbl[19] = {1'b0, 4'd2, 2'b10, 2'd2, 3'd0, 5'd9,  2'b00, 8'd9, 3'd1};

        #12;
        chk_reset("reset");
        resetn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            start = tbl[i].st;
            difficulty = tbl[i].d;
            guess_valid = tbl[i].gv;
            guess_correct = tbl[i].gc;
            tick();
            chk($sformatf("v%0d_phase", i), phase, tbl[i].ph);
            chk($sformatf("v%0d_cd", i), countdown, tbl[i].cd);
            chk($sformatf("v%0d_prog", i), progress, tbl[i].pr);
            chk($sformatf("v%0d_win", i), win, tbl[i].w);
            chk($sformatf("v%0d_to", i), timeout, tbl[i].to);
            chk($sformatf("v%0d_score", i), score, tbl[i].sc);
            chk($sformatf("v%0d_streak", i), streak, BONUS ? tbl[i].sk : 3'd0);
        end
        exp_score = 9;
        exp_streak = BONUS ? 1 : 0;

        // timer is 17 at difficulty 2; run down to 2, then a wrong guess floors it to 0
        guess_valid = 1'b0;
        for (int t = 16; t >= 2; t--) begin
            tick();
            chk($sformatf("t4_prog_%0d", t), progress, (t + 1) / 2);
            chk($sformatf("t4_phase_%0d", t), phase, 2);
        end
        guess_valid = 1'b1;
        guess_correct = 1'b0;
        tick();
        exp_streak = 0;
        chk("t4_phase", phase, 3);
        chk("t4_timeout", timeout, 1);
        chk("t4_win", win, 0);
        chk("t4_prog", progress, 0);
        chk_model("t4");
        finish_result();

        // full 20-tick countdown at difficulty 2 without guesses
        begin_round(4'd2);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("t2_prog_%0d", i), progress, (21 - i) / 2);
            chk($sformatf("t2_phase_%0d", i), phase, (i == 20) ? 3 : 2);
            chk($sformatf("t2_to_%0d", i), timeout, (i == 20) ? 1 : 0);
        end
        chk_model("t2");
        finish_result();

        // difficulty 0 behaves as 1; correct guess on the expiring tick wins
        begin_round(4'd0);
        repeat (9) tick();
        chk("t5a_prog", progress, 1);
        chk("t5a_phase", phase, 2);
        guess_valid = 1'b1;
        guess_correct = 1'b1;
        tick();
        win_m(1);
        chk("t5a_win", win, 1);
        chk("t5a_to", timeout, 0);
        chk("t5a_phase_res", phase, 3);
        chk_model("t5a");
        finish_result();

        // difficulty 15 clamps to 9: timer 90, after 9 ticks timer 81 -> progress 9
        begin_round(4'd15);
        repeat (8) tick();
        chk("t5b_prog82", progress, 10);
        tick();
        chk("t5b_prog81", progress, 9);
        guess_valid = 1'b1;
        guess_correct = 1'b1;
        tick();
        win_m(9);
        chk_model("t5b");
        finish_result();

        // repeated instant wins drive the score into saturation
        for (int r = 0; r < 26; r++) begin
            begin_round(4'd1);
            guess_valid = 1'b1;
            guess_correct = 1'b1;
            tick();
            win_m(10);
            chk_model($sformatf("sat%0d", r));
            finish_result();
        end
        chk("sat_final", score, 255);

        // asynchronous reset mid-play clears everything including score
        begin_round(4'd2);
        tick();
        tick();
        #2 resetn = 1'b0;
        #1;
        chk_reset("t6");
        @(negedge secclk);
        resetn = 1'b1;

        // streak bonus sequence: wins worth 10, 8 and 5 progress
        begin_round(4'd1);
        guess_valid = 1'b1;
        guess_correct = 1'b1;
        tick();
        chk("stk1_score", score, 10);
        finish_result();
        begin_round(4'd1);
        repeat (2) tick();
        guess_valid = 1'b1;
        guess_correct = 1'b1;
        tick();
        chk("stk2_score", score, BONUS ? 19 : 18);
        finish_result();
        begin_round(4'd1);
        repeat (5) tick();
        guess_valid = 1'b1;
        guess_correct = 1'b1;
        tick();
        chk("stk3_score", score, BONUS ? 26 : 23);
        chk("stk3_streak", streak, BONUS ? 3 : 0);
        finish_result();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
